// File: rtl/serializer.sv
// Serializer: parallel-to-serial transmitter for the SD host CMD line, bit 0 first.
// Latency: bit 0 is driven at the load edge, bit i one enabled edge later, complete at edge load+size.
// Backpressure: enable low freezes shifting with the current bit held on the line, and clears complete.
//
// Ports:
//   clk        bit clock, all state changes on posedge
//   reset      asynchronous active-high reset, returns to IDLE
//   enable     run / suspend; low in DONE rearms the block
//   load       start strobe, accepted only in IDLE with enable high
//   framesize  number of bits to send (clamped to BITS), sampled with load
//   in         parallel frame, sampled with load
//   out        registered serial data, idles high
//   oe         registered output enable for the CMD tristate
//   busy       high while shifting
//   complete   high in DONE until enable drops
module serializer #(
    parameter int BITS         = 48,
    parameter int BITS_COUNTER = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [BITS_COUNTER-1:0] framesize,
    input  logic [BITS-1:0]         in,
    output logic                    out,
    output logic                    oe,
    output logic                    busy,
    output logic                    complete
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [BITS_COUNTER-1:0] LP_MAX = BITS_COUNTER'(BITS);

    state_t                  r_state;
    logic [BITS-1:0]         r_shreg;
    logic [BITS_COUNTER-1:0] r_cnt;
    logic [BITS_COUNTER-1:0] r_size;
    logic                    r_out;
    logic                    r_oe;
    logic                    r_busy;
    logic                    r_complete;

    // Clamp the requested size so the frame never runs past the latched word.
    logic [BITS_COUNTER-1:0] w_size;
    assign w_size = (framesize > LP_MAX) ? LP_MAX : framesize;

    // The shift register is shifted right as bits go out, so the next bit is
    // always at r_shreg[1]; this avoids a variable index into the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_size     <= '0;
            r_out      <= 1'b1;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_complete <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out <= 1'b1;
                    r_oe  <= 1'b0;
                    if (enable && load) begin
                        r_shreg <= in;
                        r_size  <= w_size;
                        if (w_size == '0) begin
                            r_state    <= S_DONE;
                            r_complete <= 1'b1;
                        end else begin
                            r_out   <= in[0];
                            r_oe    <= 1'b1;
                            r_cnt   <= {{(BITS_COUNTER-1){1'b0}}, 1'b1};
                            r_busy  <= 1'b1;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    // With enable low every register holds, keeping the bit on the line.
                    if (enable) begin
                        if (r_cnt == r_size) begin
                            r_out      <= 1'b1;
                            r_oe       <= 1'b0;
                            r_cnt      <= '0;
                            r_busy     <= 1'b0;
                            r_complete <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_out   <= r_shreg[1];
                            r_shreg <= {1'b0, r_shreg[BITS-1:1]};
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_out <= 1'b1;
                    r_oe  <= 1'b0;
                    // An enable-low cycle is required before the next frame.
                    if (!enable) begin
                        r_complete <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_out      <= 1'b1;
                    r_oe       <= 1'b0;
                    r_busy     <= 1'b0;
                    r_complete <= 1'b0;
                end
            endcase
        end
    end

    assign out      = r_out;
    assign oe       = r_oe;
    assign busy     = r_busy;
    assign complete = r_complete;

endmodule

// File: tb/tb_serializer.sv
module tb_serializer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load;
    logic [7:0]  framesize;
    logic [47:0] din;
    logic        dout;
    logic        oe;
    logic        busy;
    logic        complete;

    int checks;
    int failures;

    serializer #(.BITS(48), .BITS_COUNTER(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .framesize (framesize),
        .in        (din),
        .out       (dout),
        .oe        (oe),
        .busy      (busy),
        .complete  (complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [47:0] w;
    logic [47:0] rx;
    logic [4:0]  e5;
    logic [2:0]  e3;
    int          n;
    int          cyc;

    initial begin
        checks   = 0;
        failures = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        load      = 1'b0;
        framesize = 8'd0;
        din       = '0;

        // Reset state, before any clock edge.
        #3;
        chk("rst_out", dout, 1);
        chk("rst_oe", oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_complete", complete, 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Basic CMD0 frame, 48 bits; inputs scrambled after load.
        w = 48'h40_0000_0000_95;
        enable = 1'b1; load = 1'b1; framesize = 8'd48; din = w;
        step();
        load = 1'b0; framesize = 8'd3; din = '1;
        rx = '0;
        for (int i = 0; i < 48; i++) begin
            chk("basic_bit", dout, w[i]);
            chk("basic_oe", oe, 1);
            if (i == 0 || i == 47) begin
                chk("basic_busy", busy, 1);
                chk("basic_complete_low", complete, 0);
            end
            rx[i] = dout;
            step();
        end
        chk("basic_complete", complete, 1);
        chk("basic_out_idle", dout, 1);
        chk("basic_oe_off", oe, 0);
        chk("basic_busy_off", busy, 0);
        chk("basic_rx_word", rx, w);

        // Load in DONE is ignored; complete holds until enable drops.
        load = 1'b1; framesize = 8'd8; din = 48'hFF;
        step();
        step();
        chk("done_load_complete", complete, 1);
        chk("done_load_oe", oe, 0);
        chk("done_load_busy", busy, 0);
        load = 1'b0;
        enable = 1'b0;
        step();
        chk("done_clear", complete, 0);
        enable = 1'b1;
        step();
        chk("idle_out", dout, 1);
        chk("idle_oe", oe, 0);

        // Short frame: 5 bits of ...10110 -> 0,1,1,0,1.
        e5 = 5'b10110;
        load = 1'b1; framesize = 8'd5; din = 48'hFFFF_FFFF_FFF6;
        step();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("short_bit", dout, e5[i]);
            chk("short_oe", oe, 1);
            step();
        end
        chk("short_complete", complete, 1);
        chk("short_out_idle", dout, 1);
        chk("short_oe_off", oe, 0);
        enable = 1'b0; step(); enable = 1'b1; step();

        // Clamp: framesize 200 sends exactly 48 bits; a load mid-frame is ignored.
        w = 48'hA5C3_1E7F_0B69;
        load = 1'b1; framesize = 8'd200; din = w;
        step();
        load = 1'b0;
        rx = '0; n = 0; cyc = 0;
        while (cyc < 60 && !complete) begin
            if (oe && n < 48) begin
                rx[n] = dout;
                n++;
            end
            if (cyc == 20) begin
                load = 1'b1; din = ~w; framesize = 8'd3;
            end else begin
                load = 1'b0;
            end
            cyc++;
            step();
        end
        load = 1'b0;
        chk("clamp_bits", n, 48);
        chk("clamp_cycles", cyc, 48);
        chk("clamp_complete", complete, 1);
        chk("clamp_rx_word", rx, w);
        enable = 1'b0; step(); enable = 1'b1; step();

        // Suspend: enable low for 3 cycles after bit 10 is on the line.
        w = 48'h1234_5678_9ABC;
        load = 1'b1; framesize = 8'd48; din = w;
        step();
        load = 1'b0;
        for (int i = 0; i < 48; i++) begin
            chk("susp_bit", dout, w[i]);
            if (i == 47) chk("susp_complete_low", complete, 0);
            if (i == 10) begin
                enable = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    step();
                    chk("susp_hold_bit", dout, w[10]);
                    chk("susp_hold_oe", oe, 1);
                    chk("susp_hold_busy", busy, 1);
                end
                enable = 1'b1;
            end
            step();
        end
        chk("susp_complete", complete, 1);
        chk("susp_oe_off", oe, 0);
        enable = 1'b0; step(); enable = 1'b1; step();

        // Zero-length frame.
        load = 1'b1; framesize = 8'd0; din = w;
        step();
        load = 1'b0;
        chk("zero_complete", complete, 1);
        chk("zero_oe", oe, 0);
        chk("zero_out", dout, 1);
        chk("zero_busy", busy, 0);
        step();
        chk("zero_oe_later", oe, 0);
        chk("zero_complete_hold", complete, 1);
        enable = 1'b0; step(); enable = 1'b1; step();

        // Async reset at bit 20, between clock edges.
        load = 1'b1; framesize = 8'd48; din = w;
        step();
        load = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("arst_pre_bit", dout, w[20]);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out", dout, 1);
        chk("arst_oe", oe, 0);
        chk("arst_busy", busy, 0);
        chk("arst_complete", complete, 0);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        chk("arst_post_out", dout, 1);
        chk("arst_post_oe", oe, 0);
        chk("arst_post_busy", busy, 0);

        // New frame after reset: 3 bits of 101.
        e3 = 3'b101;
        load = 1'b1; framesize = 8'd3; din = 48'h5;
        step();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_bit", dout, e3[i]);
            chk("post_oe", oe, 1);
            step();
        end
        chk("post_complete", complete, 1);
        chk("post_out_idle", dout, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
